// File: rtl/obli_col_mac.sv
// Column multiply-accumulate stage fed by the oblique buffer: nData signed products per column, nCols results per run.
// Optional build macro OBLI_MAC_SATURATE_EN clamps overflowing sums instead of wrapping them.
module obli_col_mac #(
  parameter int DATA_WIDTH = 16,
  parameter int MAX_nDATA  = 1024,
  parameter int MAX_nCOLS  = 4096,
  parameter int ACC_WIDTH  = 2*DATA_WIDTH + $clog2(MAX_nDATA)
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        start,
  input  logic [$clog2(MAX_nCOLS)+$clog2(MAX_nDATA)-1:0] config_bits,
  input  logic                                        buf_rrdy,
  input  logic [DATA_WIDTH-1:0]                       buf_data,
  output logic                                        buf_re,
  input  logic [DATA_WIDTH-1:0]                       w_data,
  input  logic                                        w_valid,
  output logic                                        w_ready,
  output logic [ACC_WIDTH-1:0]                        acc_out,
  output logic                                        acc_valid,
  input  logic                                        acc_ready,
  output logic                                        ovf,
  output logic                                        busy,
  output logic                                        done
);

  localparam int NW = $clog2(MAX_nDATA);
  localparam int CW = $clog2(MAX_nCOLS);
  localparam int PW = 2*DATA_WIDTH;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                       state_q;
  logic [NW-1:0]                n_data_q, elem_cnt_q;
  logic [CW-1:0]                n_cols_q, issue_col_q, out_col_q;
  logic signed [PW-1:0]         prod_q;
  logic                         v1_q, last1_q, first1_q;
  logic signed [ACC_WIDTH-1:0]  acc_q, acc_out_q;
  logic                         acc_valid_q, ovf_q, done_q;

  logic [NW-1:0]                cfg_n_data;
  logic [CW-1:0]                cfg_n_cols;
  logic                         last, stall, fire, accept, ovf_hit;
  logic signed [ACC_WIDTH-1:0]  acc_base, sum_d;
  logic signed [ACC_WIDTH:0]    sum_wide;

  assign cfg_n_data = config_bits[NW-1:0];
  assign cfg_n_cols = config_bits[CW+NW-1:NW];

  // NOTE: every always_comb output gets a default first so no path can leave a latch behind.
  always_comb begin
    last     = 1'b0;
    stall    = 1'b0;
    fire     = 1'b0;
    accept   = acc_valid_q && acc_ready;
    acc_base = first1_q ? '0 : acc_q;
    sum_wide = (ACC_WIDTH+1)'(acc_base) + (ACC_WIDTH+1)'(prod_q);
    ovf_hit  = sum_wide[ACC_WIDTH] ^ sum_wide[ACC_WIDTH-1];
    sum_d    = sum_wide[ACC_WIDTH-1:0];
`ifdef OBLI_MAC_SATURATE_EN
    if (ovf_hit)
      sum_d = sum_wide[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                  : {1'b0, {(ACC_WIDTH-1){1'b1}}};
`endif
    if (state_q == RUN) begin
      last  = (elem_cnt_q == n_data_q - NW'(1));
      // A last element may only enter once the single result slot is guaranteed free.
      stall = last && ((acc_valid_q && !acc_ready) || (v1_q && last1_q));
      fire  = buf_rrdy && w_valid && !stall;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      n_data_q    <= '0;
      n_cols_q    <= '0;
      elem_cnt_q  <= '0;
      issue_col_q <= '0;
      out_col_q   <= '0;
      prod_q      <= '0;
      v1_q        <= 1'b0;
      last1_q     <= 1'b0;
      first1_q    <= 1'b0;
      acc_q       <= '0;
      acc_out_q   <= '0;
      acc_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;

      v1_q <= fire;
      if (fire) begin
        prod_q   <= PW'($signed(buf_data)) * PW'($signed(w_data));
        last1_q  <= last;
        first1_q <= (elem_cnt_q == '0);
      end

      if (v1_q) begin
        acc_q <= sum_d;
        if (ovf_hit) ovf_q <= 1'b1;
      end

      // A same-cycle accept and new write leaves valid set with the fresh value.
      if (v1_q && last1_q) begin
        acc_out_q   <= sum_d;
        acc_valid_q <= 1'b1;
      end else if (accept) begin
        acc_valid_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (start && cfg_n_data != '0 && cfg_n_cols != '0) begin
            n_data_q    <= cfg_n_data;
            n_cols_q    <= cfg_n_cols;
            elem_cnt_q  <= '0;
            issue_col_q <= '0;
            out_col_q   <= '0;
            ovf_q       <= 1'b0;
            state_q     <= RUN;
          end
        end
        RUN: begin
          if (fire) begin
            elem_cnt_q <= last ? '0 : elem_cnt_q + NW'(1);
            if (last) begin
              issue_col_q <= issue_col_q + CW'(1);
              if (issue_col_q == n_cols_q - CW'(1)) state_q <= DRAIN;
            end
          end
        end
        default: ;
      endcase

      if (state_q != IDLE && accept) begin
        out_col_q <= out_col_q + CW'(1);
        if (out_col_q == n_cols_q - CW'(1)) begin
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
      end
    end
  end

  assign buf_re    = fire;
  assign w_ready   = fire;
  assign acc_out   = acc_out_q;
  assign acc_valid = acc_valid_q;
  assign ovf       = ovf_q;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;

endmodule
